// File: rtl/keypad_decoder_if.sv
// Scan-sample handshake and decoded key outputs between the keypad row scanner
// and keypad_decoder. The master side (scanner or testbench) drives the scan
// signals; the slave side (decoder) drives the key and display outputs.
interface keypad_decoder_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       press;
    logic [3:0] key;
    logic       key_valid;
    logic       held;
    logic [3:0] digit0;
    logic [3:0] digit1;

    modport master (
        output rows, cols, press,
        input  key, key_valid, held, digit0, digit1
    );

    modport slave (
        input  rows, cols, press,
        output key, key_valid, held, digit0, digit1
    );
endinterface

// File: rtl/keypad_decoder.sv
// Debounces raw keypad scan samples into hexadecimal key events. A candidate
// key must collect DEBOUNCE_HITS matching samples within WINDOW cycles. Once
// accepted it is held until RELEASE_CYCLES cycles pass with no matching sample.
// Optional feature: define KEYPAD_ROLLOVER_EN to let a different key pressed
// while one is held start a new confirmation (n-key rollover).
module keypad_decoder #(
    parameter int unsigned DEBOUNCE_HITS  = 4,
    parameter int unsigned WINDOW         = 64,
    parameter int unsigned RELEASE_CYCLES = 32
) (
    input logic             clk,
    input logic             reset,
    keypad_decoder_if.slave kp
);

    localparam logic [7:0] HitsTarget = 8'(DEBOUNCE_HITS);
    localparam logic [7:0] WinLast    = 8'(WINDOW - 1);
    localparam logic [7:0] RelLast    = 8'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConfirm,
        StHeld
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] hits_q, hits_d;
    logic [7:0] silence_q, silence_d;
    logic [3:0] key_q, key_d;
    logic       key_valid_q, key_valid_d;
    logic       held_q, held_d;
    logic [3:0] digit0_q, digit0_d;
    logic [3:0] digit1_q, digit1_d;

    logic       sample_valid;
    logic [3:0] sample_code;
    logic       emit;
    logic [3:0] emit_code;
    logic [7:0] hits_inc;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Classify this cycle's scan inputs and decode the key code.
    always_comb begin
        sample_valid = kp.press && is_onehot(kp.rows) && is_onehot(kp.cols);
        sample_code  = code_of(onehot_idx(kp.rows), onehot_idx(kp.cols));
    end

    // Debounce state machine and emit bookkeeping.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        hits_d      = hits_q;
        silence_d   = silence_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        digit0_d    = digit0_q;
        digit1_d    = digit1_q;
        emit        = 1'b0;
        emit_code   = cand_q;
        hits_inc    = sat_inc(hits_q);

        case (state_q)
            StIdle: begin
                if (sample_valid) begin
                    cand_d = sample_code;
                    hits_d = 8'd1;
                    cnt_d  = 8'd0;
                    if (HitsTarget == 8'd1) begin
                        emit      = 1'b1;
                        emit_code = sample_code;
                        silence_d = 8'd0;
                        state_d   = StHeld;
                    end else begin
                        state_d = StConfirm;
                    end
                end
            end

            StConfirm: begin
                cnt_d = sat_inc(cnt_q);
                if (sample_valid && (sample_code == cand_q)) begin
                    hits_d = hits_inc;
                    // The final hit wins even on the window's last cycle.
                    if (hits_inc >= HitsTarget) begin
                        emit      = 1'b1;
                        silence_d = 8'd0;
                        state_d   = StHeld;
                    end else if (cnt_q == WinLast) begin
                        state_d = StIdle;
                    end
                end else if (sample_valid) begin
                    state_d = StIdle;
                end else if (cnt_q == WinLast) begin
                    state_d = StIdle;
                end
            end

            StHeld: begin
                if (sample_valid && (sample_code == cand_q)) begin
                    silence_d = 8'd0;
`ifdef KEYPAD_ROLLOVER_EN
                end else if (sample_valid) begin
                    cand_d = sample_code;
                    hits_d = 8'd1;
                    cnt_d  = 8'd0;
                    if (HitsTarget == 8'd1) begin
                        emit      = 1'b1;
                        emit_code = sample_code;
                        silence_d = 8'd0;
                    end else begin
                        state_d = StConfirm;
                    end
`endif
                end else begin
                    silence_d = sat_inc(silence_q);
                    if (silence_q == RelLast) state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase

        if (emit) begin
            key_d       = emit_code;
            key_valid_d = 1'b1;
            digit1_d    = digit0_q;
            digit0_d    = emit_code;
        end

        held_d = (state_d == StHeld);
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            cnt_q       <= 8'd0;
            hits_q      <= 8'd0;
            silence_q   <= 8'd0;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            held_q      <= 1'b0;
            digit0_q    <= 4'd0;
            digit1_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            hits_q      <= hits_d;
            silence_q   <= silence_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            held_q      <= held_d;
            digit0_q    <= digit0_d;
            digit1_q    <= digit1_d;
        end
    end

    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.held      = held_q;
    assign kp.digit0    = digit0_q;
    assign kp.digit1    = digit1_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder with default parameters.
// A time-stamp based reference model tracks every cycle; table-driven key-map
// vectors, hand-written corner sequences and random scan traffic run against it.
module tb_keypad_decoder;

    localparam int Hits    = 4;
    localparam int Window  = 64;
    localparam int Release = 32;

    logic clk = 1'b0;
    logic rst_n;
    keypad_decoder_if kp ();

    keypad_decoder dut (
        .clk   (clk),
        .reset (rst_n),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic prev_kv = 1'b0;

    // Reference model: phases by name, timing from cycle time stamps.
    int   now = 0;
    int   m_phase = 0;   // 0 waiting, 1 qualifying, 2 key down
    int   m_start, m_last, m_hits;
    logic [3:0] m_cand, m_key, m_d0, m_d1;
    logic m_kv, m_held;
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    function automatic int bit_pos(input logic [3:0] v);
        int p = 0;
        for (int i = 0; i < 4; i++) if (v[i]) p = i;
        return p;
    endfunction

    function automatic void m_emit(input logic [3:0] code);
        m_kv  = 1'b1;
        m_key = code;
        m_d1  = m_d0;
        m_d0  = code;
    endfunction

    function automatic void model_step(input bit rn, input bit p,
                                       input logic [3:0] r, input logic [3:0] c);
        bit valid;
        logic [3:0] code;
        now++;
        m_kv = 1'b0;
        if (!rn) begin
            m_phase = 0; m_key = 4'h0; m_d0 = 4'h0; m_d1 = 4'h0; m_held = 1'b0;
            return;
        end
        valid = p && ($countones(r) == 1) && ($countones(c) == 1);
        code  = keymap[bit_pos(r) * 4 + bit_pos(c)];
        if (m_phase == 0) begin
            if (valid) begin
                m_cand = code; m_start = now; m_hits = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (valid && code == m_cand) begin
                m_hits++;
                if (m_hits >= Hits) begin
                    m_emit(m_cand); m_phase = 2; m_last = now;
                end else if (now - m_start == Window) begin
                    m_phase = 0;
                end
            end else if (valid || (now - m_start == Window)) begin
                m_phase = 0;
            end
        end else begin
            if (valid && code == m_cand) begin
                m_last = now;
`ifdef KEYPAD_ROLLOVER_EN
            end else if (valid) begin
                m_cand = code; m_start = now; m_hits = 1; m_phase = 1;
`endif
            end else if (now - m_last == Release) begin
                m_phase = 0;
            end
        end
        m_held = (m_phase == 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rn, input bit p, input logic [3:0] r, input logic [3:0] c);
        rst_n    = rn;
        kp.press = p;
        kp.rows  = r;
        kp.cols  = c;
        @(posedge clk);
        model_step(rn, p, r, c);
        #1;
        chk("model", 32'({kp.key, kp.key_valid, kp.held, kp.digit0, kp.digit1}),
            32'({m_key, m_kv, m_held, m_d0, m_d1}));
        chk("kv_back_to_back", 32'(kp.key_valid & prev_kv), 32'd0);
        prev_kv = kp.key_valid;
        if (kp.key_valid) pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic smp(input logic [3:0] r, input logic [3:0] c);
        cyc(1'b1, 1'b1, r, c);
    endtask

    typedef struct {
        logic [3:0] rows;
        logic [3:0] cols;
        bit         accept;
        logic [3:0] key;
    } vec_t;

    vec_t vecs [18];
    int   p0, n;
    logic [3:0] cur_r, cur_c;

    initial begin
        vecs[0]  = '{4'b0001, 4'b0001, 1'b1, 4'h1};
        vecs[1]  = '{4'b0001, 4'b0010, 1'b1, 4'h2};
        vecs[2]  = '{4'b0001, 4'b0100, 1'b1, 4'h3};
        vecs[3]  = '{4'b0001, 4'b1000, 1'b1, 4'hA};
        vecs[4]  = '{4'b0010, 4'b0001, 1'b1, 4'h4};
        vecs[5]  = '{4'b0010, 4'b0010, 1'b1, 4'h5};
        vecs[6]  = '{4'b0010, 4'b0100, 1'b1, 4'h6};
        vecs[7]  = '{4'b0010, 4'b1000, 1'b1, 4'hB};
        vecs[8]  = '{4'b0100, 4'b0001, 1'b1, 4'h7};
        vecs[9]  = '{4'b0100, 4'b0010, 1'b1, 4'h8};
        vecs[10] = '{4'b0100, 4'b0100, 1'b1, 4'h9};
        vecs[11] = '{4'b0100, 4'b1000, 1'b1, 4'hC};
        vecs[12] = '{4'b1000, 4'b0001, 1'b1, 4'hE};
        vecs[13] = '{4'b1000, 4'b0010, 1'b1, 4'h0};
        vecs[14] = '{4'b1000, 4'b0100, 1'b1, 4'hF};
        vecs[15] = '{4'b1000, 4'b1000, 1'b1, 4'hD};
        vecs[16] = '{4'b0101, 4'b0001, 1'b0, 4'h0};
        vecs[17] = '{4'b0001, 4'b0011, 1'b0, 4'h0};

        // Reset held for 3 cycles while a valid sample is presented.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0001, 4'b0001);
        chk("reset_outputs", 32'({kp.key, kp.key_valid, kp.held, kp.digit0, kp.digit1}), 32'd0);

        // Single accepted press: sample every 5 cycles, 4 samples of key 6.
        p0 = pulses;
        for (int s = 0; s < 4; s++) begin
            smp(4'b0010, 4'b0100);
            if (s < 3) idle(4);
        end
        chk("single_kv", 32'(kp.key_valid), 32'd1);
        chk("single_key", 32'(kp.key), 32'h6);
        chk("single_digits", 32'({kp.digit0, kp.digit1}), 32'h60);
        chk("single_held", 32'(kp.held), 32'd1);
        n = 0;
        while (kp.held && n < 100) begin
            idle(1);
            n++;
        end
        chk("release_latency", 32'(n), 32'd32);
        chk("single_pulses", 32'(pulses - p0), 32'd1);

        // Bounce: code 5 then code 8.
        p0 = pulses;
        smp(4'b0010, 4'b0010);
        smp(4'b0100, 4'b0010);
        smp(4'b0100, 4'b0010);
        idle(70);
        chk("bounce_pulses", 32'(pulses - p0), 32'd0);
        chk("bounce_held", 32'(kp.held), 32'd0);

        // Window expiry: 3 matching samples spread across the window.
        p0 = pulses;
        for (int s = 0; s < 3; s++) begin
            smp(4'b0001, 4'b0100);
            idle(20);
        end
        idle(30);
        chk("window_pulses", 32'(pulses - p0), 32'd0);

        // Invalid samples repeated 10 times each.
        p0 = pulses;
        for (int s = 0; s < 10; s++) smp(4'b0001, 4'b0011);
        for (int s = 0; s < 10; s++) smp(4'b0101, 4'b0001);
        chk("invalid_pulses", 32'(pulses - p0), 32'd0);
        chk("invalid_held", 32'(kp.held), 32'd0);

        // History shift: key 1, release, key D.
        p0 = pulses;
        for (int s = 0; s < 4; s++) smp(4'b0001, 4'b0001);
        idle(40);
        for (int s = 0; s < 4; s++) smp(4'b1000, 4'b1000);
        chk("history_digits", 32'({kp.digit0, kp.digit1}), 32'hD1);
        chk("history_pulses", 32'(pulses - p0), 32'd2);
        idle(40);

        // Rollover: hold key 1, then key 2 presented while 1 is still held.
        p0 = pulses;
        for (int s = 0; s < 4; s++) smp(4'b0001, 4'b0001);
        idle(3);
        for (int s = 0; s < 4; s++) smp(4'b0001, 4'b0010);
`ifdef KEYPAD_ROLLOVER_EN
        chk("rollover_pulses", 32'(pulses - p0), 32'd2);
        chk("rollover_key", 32'(kp.key), 32'h2);
        chk("rollover_digit1", 32'(kp.digit1), 32'h1);
`else
        chk("rollover_pulses", 32'(pulses - p0), 32'd1);
        chk("rollover_key", 32'(kp.key), 32'h1);
        chk("rollover_digit1", 32'(kp.digit1), 32'hD);
`endif
        idle(40);

        // Table: every key-map position plus invalid patterns.
        for (int v = 0; v < 18; v++) begin
            idle(40);
            p0 = pulses;
            for (int s = 0; s < 4; s++) smp(vecs[v].rows, vecs[v].cols);
            chk($sformatf("table%0d_kv", v), 32'(kp.key_valid), 32'(vecs[v].accept));
            if (vecs[v].accept) chk($sformatf("table%0d_key", v), 32'(kp.key), 32'(vecs[v].key));
            chk($sformatf("table%0d_pulses", v), 32'(pulses - p0), 32'(vecs[v].accept));
        end

        // Random scan traffic against the model.
        cur_r = 4'b0001;
        cur_c = 4'b0001;
        for (int i = 0; i < 4000; i++) begin
            bit rn, p;
            logic [3:0] r, c;
            if ($urandom_range(0, 299) == 0) begin
                cur_r = 4'(1 << $urandom_range(0, 3));
                cur_c = 4'(1 << $urandom_range(0, 3));
            end
            rn = ($urandom_range(0, 399) != 0);
            p  = ($urandom_range(0, 2) == 0);
            r  = cur_r;
            c  = cur_c;
            if ($urandom_range(0, 19) == 0) begin
                r = 4'($urandom);
                c = 4'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                r = 4'(1 << $urandom_range(0, 3));
                c = 4'(1 << $urandom_range(0, 3));
            end
            cyc(rn, p, r, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Consumes the row-scan handshake from the keypad row scanner (`rows`, `cols`, `press`) and turns raw scan samples into debounced hexadecimal key events. It qualifies each candidate key over several scan samples, emits one `key_valid` pulse per accepted press, and tracks release. It also keeps a two-digit history (`digit0`/`digit1`) for the seven-segment display path.

## Interface
- `DEBOUNCE_HITS`, default 4: matching valid samples required to accept a key; range 1..255.
- `WINDOW`, default 64: cycles allowed in CONFIRM to collect the hits; range 2..255.
- `RELEASE_CYCLES`, default 32: cycles without a matching sample before a held key counts as released; range 2..255.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `rows`, input, 4: row drive from the scanner; active-high, one-hot while scanning.
- `cols`, input, 4: synchronized column sense; active-high.
- `press`, input, 1: scanner strobe saying `rows`/`cols` form a press sample this cycle.
- `key`, output, 4: hex code of the last accepted key.
- `key_valid`, output, 1: one-cycle pulse when `key` updates.
- `held`, output, 1: high while an accepted key has not yet been released.
- `digit0`, output, 4: most recent accepted key.
- `digit1`, output, 4: previous accepted key.

## Operation
- **Valid sample:** `press`=1, `rows` exactly one-hot, and `cols` exactly one bit set. Any other cycle is a non-sample, including `press`=1 with multiple columns or a non-one-hot `rows`.
- **Code map, row index r by column index c:**
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **Internal registers:** `cand`[3:0]; `cnt`[7:0], `hits`[7:0] and `silence`[7:0], all unsigned and saturating at 255.
- **IDLE:**
  - On a valid sample: `cand`=code, `hits`=1, `cnt`=0, go to CONFIRM.
  - If `DEBOUNCE_HITS`=1, go directly to HELD and emit instead.
- **CONFIRM:**
  - `cnt` increments every cycle.
  - Valid sample with code == `cand`: `hits`+1.
  - Valid sample with code != `cand`: go to IDLE (bounce reject).
  - `hits` reaches `DEBOUNCE_HITS`: emit and go to HELD, with `silence`=0.
  - Otherwise, if `cnt` == `WINDOW`-1: go to IDLE.
- **Emit**, registered on the transition edge:
  - `key`=`cand`, `key_valid`=1 for exactly one cycle.
  - `digit1`←`digit0`, `digit0`←`cand`.
- **HELD:**
  - Matching valid sample: `silence`=0.
  - Any other cycle: `silence`+1.
  - Non-matching valid sample: ignored; see Configuration.
  - `silence` == `RELEASE_CYCLES`-1: go to IDLE.
- `held` = (state == HELD), registered.

## Timing
- **Reset:** `key`=0, `key_valid`=0, `held`=0, `digit0`=0, `digit1`=0, state IDLE, all counters 0.
  - Reset has priority over all other activity and takes effect at the next edge.
  - Reset mid-CONFIRM or mid-HELD discards the candidate and emits nothing.
- **Acceptance latency:** `key_valid`, `key`, `digit0`/`digit1` and `held` all update on the edge that samples the DEBOUNCE_HITS-th matching sample, so they are visible the following cycle.
- `key_valid` is never high for two consecutive cycles.
- **Simultaneous events:**
  - In CONFIRM, the final hit landing on `cnt`==`WINDOW`-1 emits; emit beats window expiry.
  - In HELD, a matching sample on the expiry cycle resets `silence` and the state stays HELD.
  - A mismatch landing on the window-expiry cycle goes to IDLE, with the same outcome either way.
- **Release to re-arm:** a valid sample in the first IDLE cycle after release is accepted as a new candidate.

## Configuration
- Macro: `KEYPAD_ROLLOVER_EN`.
- **Defined:** in HELD, a valid sample with code != `cand` loads `cand`=code, `hits`=1, `cnt`=0 and moves to CONFIRM. This gives n-key rollover, and the new key emits normally once confirmed. `held` drops while in CONFIRM.
- **Undefined:** non-matching samples in HELD are ignored. A second key is accepted only after the first is released.

## Test plan
- **Reset values:** assert reset for 3 cycles with `press`=1, `rows`=0001, `cols`=0001 -> all outputs 0, no `key_valid`.
- **Single accepted press:** defaults; `rows`=0010, `cols`=0100, one `press` cycle every 5 cycles, 4 samples -> single `key_valid` with `key`=6 one cycle after the 4th sample; `digit0`=6, `digit1`=0, `held`=1. Then stop `press` -> `held`=0 exactly 32 cycles after the last sample.
- **Bounce reject and window expiry:**
  - Sample code 5 followed by one sample of code 8 -> no `key_valid`, return to IDLE.
  - Separately, only 3 matching samples within 64 cycles -> no `key_valid`.
- **Invalid samples:** `cols`=0011, or `rows`=0101, with `press`=1 repeated 10 times -> no state change, no `key_valid`.
- **History shift:** accept key 1 (r0,c0), release, then accept key D (r3,c3) -> `digit0`=D, `digit1`=1, exactly two `key_valid` pulses.
- **Rollover macro:** hold key 1 while interleaving valid samples of key 2 (r0,c1) -> without the macro, one pulse (`key`=1); with `KEYPAD_ROLLOVER_EN`, a second pulse with `key`=2 and `digit1`=1.
